// File: rtl/seg7_decoder_monitor_if.sv
// Bundle between a 7-segment observer and its consumer: raw segment drive in,
// decoded digit, acceptance pulse, period measurement and change count out.
interface seg7_decoder_monitor_if #(
    parameter int PERIOD_W = 24
);
    logic [6:0]          segments;
    logic [3:0]          digit;
    logic                known;
    logic                blank;
    logic                update;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic [7:0]          change_count;

    modport master (
        output segments,
        input  digit, known, blank, update, period, period_valid, change_count
    );

    modport slave (
        input  segments,
        output digit, known, blank, update, period, period_valid, change_count
    );
endinterface

// File: rtl/seg7_decoder_monitor.sv
// Debounces an observed 7-segment drive, decodes accepted glyphs to hex and
// measures the cycle distance between successive accepted changes.
module seg7_decoder_monitor #(
    parameter int STABLE_CYCLES = 16,
    parameter int PERIOD_W      = 24
) (
    input logic                  clk,
    input logic                  reset,
    seg7_decoder_monitor_if.slave bus
);
    localparam logic [0:0]          WAIT_FIRST = 1'b0;
    localparam logic [0:0]          TRACK      = 1'b1;
    localparam logic [7:0]          STAB_LAST  = 8'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PCNT_MAX   = '1;

    logic [0:0]          state;
    logic [6:0]          seg_q;
    logic [6:0]          candidate;
    logic [6:0]          accepted;
    logic [7:0]          stab_cnt;
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] pcnt_next;

    logic [3:0]          digit_r;
    logic                known_r;
    logic                blank_r;
    logic                update_r;
    logic [PERIOD_W-1:0] period_r;
    logic                period_valid_r;
    logic [7:0]          change_count_r;

    logic                accept;
    logic [3:0]          dec_digit;
    logic                dec_known;

    always_comb begin
        dec_digit = 4'h0;
        dec_known = 1'b1;
        case (candidate)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: dec_known = 1'b0;
        endcase
    end

    // Acceptance keys off the candidate alone, so a seg_q change on this edge
    // still completes the pending acceptance while tracking restarts below.
    assign accept    = (stab_cnt == STAB_LAST) && (candidate != accepted);
    // The counter clears on acceptance, so the edge distance is one more than it holds.
    assign pcnt_next = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_FIRST;
            seg_q          <= 7'h00;
            candidate      <= 7'h00;
            accepted       <= 7'h00;
            stab_cnt       <= 8'd0;
            pcnt           <= '0;
            digit_r        <= 4'h0;
            known_r        <= 1'b0;
            blank_r        <= 1'b0;
            update_r       <= 1'b0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
            change_count_r <= 8'd0;
        end else begin
            seg_q    <= bus.segments;
            update_r <= 1'b0;

            if (seg_q != candidate) begin
                candidate <= seg_q;
                stab_cnt  <= 8'd0;
            end else if (stab_cnt != STAB_LAST) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            if (accept) begin
                accepted       <= candidate;
                update_r       <= 1'b1;
                digit_r        <= dec_digit;
                known_r        <= dec_known;
                blank_r        <= (candidate == 7'h00);
                change_count_r <= change_count_r + 8'd1;
                pcnt           <= '0;
                state          <= TRACK;
                if (state == TRACK) begin
                    period_r       <= pcnt_next;
                    period_valid_r <= 1'b1;
                end
            end else if (pcnt != PCNT_MAX) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign bus.digit        = digit_r;
    assign bus.known        = known_r;
    assign bus.blank        = blank_r;
    assign bus.update       = update_r;
    assign bus.period       = period_r;
    assign bus.period_valid = period_valid_r;
    assign bus.change_count = change_count_r;
endmodule

// File: tb/tb_seg7_decoder_monitor.sv
// Directed checks of the 7-segment monitor: latency, decode, glitch rejection,
// period measurement, count wrap and reset abort.
module tb_seg7_decoder_monitor;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    seg7_decoder_monitor_if #(.PERIOD_W(24)) bus ();

    seg7_decoder_monitor #(.STABLE_CYCLES(16), .PERIOD_W(24)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps up to max_edges, returning the first edge with update high (0 if none)
    // and the number of update pulses observed.
    task automatic run_edges(input int max_edges, output int first, output int pulses);
        first  = 0;
        pulses = 0;
        for (int e = 1; e <= max_edges; e++) begin
            step();
            if (bus.update === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
    endtask

    task automatic test_reset();
        int first, pulses;
        reset        = 1'b1;
        bus.segments = 7'h00;
        step();
        step();
        n_cmp++;
        if ({bus.digit, bus.known, bus.blank, bus.update} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got digit=%h known=%b blank=%b update=%b, want all 0",
                     bus.digit, bus.known, bus.blank, bus.update);
        end
        n_cmp++;
        if (bus.period !== 24'd0 || bus.period_valid !== 1'b0 || bus.change_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_period: got period=%0d pv=%b cc=%0d, want 0 0 0",
                     bus.period, bus.period_valid, bus.change_count);
        end
        reset = 1'b0;
        run_edges(30, first, pulses);
        n_cmp++;
        if (pulses !== 0 || bus.change_count !== 8'd0) begin
            n_bad++;
            $display("FAIL zero_after_reset: got pulses=%0d cc=%0d, want 0 0", pulses, bus.change_count);
        end
    endtask

    task automatic test_first_and_period();
        int first, pulses, t0;
        bus.segments = 7'h3F;
        t0 = cyc;
        run_edges(30, first, pulses);
        n_cmp++;
        if (first !== 18 || pulses !== 1) begin
            n_bad++;
            $display("FAIL first_latency: got edge=%0d pulses=%0d, want 18 1", first, pulses);
        end
        n_cmp++;
        if (bus.digit !== 4'h0 || bus.known !== 1'b1 || bus.blank !== 1'b0 ||
            bus.change_count !== 8'd1 || bus.period_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_decode: got digit=%h known=%b blank=%b cc=%0d pv=%b, want 0 1 0 1 0",
                     bus.digit, bus.known, bus.blank, bus.change_count, bus.period_valid);
        end
        while (cyc < t0 + 1000) step();
        bus.segments = 7'h06;
        run_edges(30, first, pulses);
        n_cmp++;
        if (first !== 18 || pulses !== 1) begin
            n_bad++;
            $display("FAIL second_latency: got edge=%0d pulses=%0d, want 18 1", first, pulses);
        end
        n_cmp++;
        if (bus.digit !== 4'h1 || bus.period !== 24'd1000 || bus.period_valid !== 1'b1 ||
            bus.change_count !== 8'd2) begin
            n_bad++;
            $display("FAIL period_1000: got digit=%h period=%0d pv=%b cc=%0d, want 1 1000 1 2",
                     bus.digit, bus.period, bus.period_valid, bus.change_count);
        end
    endtask

    task automatic test_glitch();
        int first, pulses, p2;
        bus.segments = 7'h5B;
        run_edges(10, first, pulses);
        bus.segments = 7'h06;
        run_edges(40, first, p2);
        n_cmp++;
        if (pulses + p2 !== 0) begin
            n_bad++;
            $display("FAIL glitch_update: got pulses=%0d, want 0", pulses + p2);
        end
        n_cmp++;
        if (bus.digit !== 4'h1 || bus.known !== 1'b1 || bus.change_count !== 8'd2 ||
            bus.period !== 24'd1000) begin
            n_bad++;
            $display("FAIL glitch_hold: got digit=%h known=%b cc=%0d period=%0d, want 1 1 2 1000",
                     bus.digit, bus.known, bus.change_count, bus.period);
        end
    endtask

    task automatic test_unknown_blank();
        int first, pulses;
        bus.segments = 7'h49;
        run_edges(20, first, pulses);
        n_cmp++;
        if (first !== 18 || pulses !== 1) begin
            n_bad++;
            $display("FAIL unknown_latency: got edge=%0d pulses=%0d, want 18 1", first, pulses);
        end
        n_cmp++;
        if (bus.known !== 1'b0 || bus.digit !== 4'h0 || bus.blank !== 1'b0 || bus.change_count !== 8'd3) begin
            n_bad++;
            $display("FAIL unknown_decode: got known=%b digit=%h blank=%b cc=%0d, want 0 0 0 3",
                     bus.known, bus.digit, bus.blank, bus.change_count);
        end
        bus.segments = 7'h00;
        run_edges(25, first, pulses);
        n_cmp++;
        if (first !== 18 || bus.blank !== 1'b1 || bus.known !== 1'b0 || bus.period !== 24'd20) begin
            n_bad++;
            $display("FAIL blank_decode: got edge=%0d blank=%b known=%b period=%0d, want 18 1 0 20",
                     first, bus.blank, bus.known, bus.period);
        end
    endtask

    task automatic test_wrap();
        int first, pulses, total;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total = 0;
        for (int i = 0; i < 256; i++) begin
            bus.segments = (i % 2 == 0) ? 7'h3F : 7'h06;
            run_edges(20, first, pulses);
            total += pulses;
            if (i == 254) begin
                n_cmp++;
                if (bus.change_count !== 8'd255) begin
                    n_bad++;
                    $display("FAIL wrap_255: got cc=%0d, want 255", bus.change_count);
                end
            end
        end
        n_cmp++;
        if (total !== 256 || bus.change_count !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_count: got pulses=%0d cc=%0d, want 256 0", total, bus.change_count);
        end
        n_cmp++;
        if (bus.digit !== 4'h1 || bus.period !== 24'd20 || bus.period_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_state: got digit=%h period=%0d pv=%b, want 1 20 1",
                     bus.digit, bus.period, bus.period_valid);
        end
    endtask

    task automatic test_reset_abort();
        int first, pulses, p2;
        bus.segments = 7'h7F;
        run_edges(9, first, pulses);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (pulses !== 0 || bus.update !== 1'b0 || bus.change_count !== 8'd0 || bus.period_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reset: got pulses=%0d update=%b cc=%0d pv=%b, want 0 0 0 0",
                     pulses, bus.update, bus.change_count, bus.period_valid);
        end
        run_edges(30, first, p2);
        n_cmp++;
        if (first !== 18 || p2 !== 1) begin
            n_bad++;
            $display("FAIL requalify_latency: got edge=%0d pulses=%0d, want 18 1", first, p2);
        end
        n_cmp++;
        if (bus.digit !== 4'h8 || bus.known !== 1'b1 || bus.change_count !== 8'd1 || bus.period_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL requalify_decode: got digit=%h known=%b cc=%0d pv=%b, want 8 1 1 0",
                     bus.digit, bus.known, bus.change_count, bus.period_valid);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        cyc          = 0;
        reset        = 1'b1;
        bus.segments = 7'h00;
        test_reset();
        test_first_and_period();
        test_glitch();
        test_unknown_blank();
        test_wrap();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
